// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Big-endian byte/half/word load-store front-end for a
//                word-organised data RAM; sub-word stores use read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  Wr,
    input  logic [1:0]            Size,
    input  logic                  Signed,
    input  logic [31:0]           Addr,
    input  logic [DATA_WIDTH-1:0] WData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Fault,
    output logic [DATA_WIDTH-1:0] RData,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    output logic                  RamWrite,
    output logic [DATA_WIDTH-1:0] RamWriteData,
    input  logic [DATA_WIDTH-1:0] RamReadData
);

    localparam logic [1:0] C_SIZE_BYTE = 2'b00;
    localparam logic [1:0] C_SIZE_HALF = 2'b01;
    localparam logic [1:0] C_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic [1:0]              size_q, size_d;
    logic                    signed_q, signed_d;
    logic [1:0]              off_q, off_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   ramaddr_q, ramaddr_d;
    logic [DATA_WIDTH-1:0]   ramwdata_q, ramwdata_d;

    logic                    w_fault;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load;
    logic [DATA_WIDTH-1:0]   w_merged;

    // Acceptance-time checks on the live request inputs
    always_comb begin
        w_fault = 1'b0;
        if (Size == 2'b11)                                  w_fault = 1'b1;
        if (Size == C_SIZE_HALF && Addr[0])                 w_fault = 1'b1;
        if (Size == C_SIZE_WORD && Addr[1:0] != 2'b00)      w_fault = 1'b1;
        if ((Addr >> (ADDR_WIDTH + 2)) != 32'd0)            w_fault = 1'b1;
    end

    // Lane extraction and merge: byte offset 0 is the most significant byte
    always_comb begin
        w_byte   = 8'h00;
        w_half   = off_q[1] ? RamReadData[15:0] : RamReadData[31:16];
        w_merged = RamReadData;
        case (off_q)
            2'd0:    w_byte = RamReadData[31:24];
            2'd1:    w_byte = RamReadData[23:16];
            2'd2:    w_byte = RamReadData[15:8];
            default: w_byte = RamReadData[7:0];
        endcase
        if (size_q == C_SIZE_BYTE) begin
            case (off_q)
                2'd0:    w_merged[31:24] = wdata_q[7:0];
                2'd1:    w_merged[23:16] = wdata_q[7:0];
                2'd2:    w_merged[15:8]  = wdata_q[7:0];
                default: w_merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            w_merged[15:0]  = wdata_q;
        end else begin
            w_merged[31:16] = wdata_q;
        end
        case (size_q)
            C_SIZE_BYTE: w_load = {{24{signed_q & w_byte[7]}}, w_byte};
            C_SIZE_HALF: w_load = {{16{signed_q & w_half[15]}}, w_half};
            default:     w_load = RamReadData;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        signed_d   = signed_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        fault_d    = fault_q;
        rdata_d    = rdata_q;
        ramaddr_d  = ramaddr_q;
        ramwdata_d = ramwdata_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    wr_d      = Wr;
                    size_d    = Size;
                    signed_d  = Signed;
                    off_d     = Addr[1:0];
                    wdata_d   = WData[15:0];
                    ramaddr_d = Addr[ADDR_WIDTH+1:2];
                    if (w_fault) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else if (Wr && Size == C_SIZE_WORD) begin
                        ramwdata_d = WData;
                        state_d    = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                if (wr_q) begin
                    ramwdata_d = w_merged;
                    state_d    = S_WR;
                end else begin
                    rdata_d = w_load;
                    state_d = S_DONE;
                end
            end
            S_WR:  state_d = S_DONE;
            S_DONE: begin
                fault_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0000;
            fault_q    <= 1'b0;
            rdata_q    <= '0;
            ramaddr_q  <= '0;
            ramwdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            fault_q    <= fault_d;
            rdata_q    <= rdata_d;
            ramaddr_q  <= ramaddr_d;
            ramwdata_q <= ramwdata_d;
        end
    end

    // Gating with Reset suppresses the write on an edge where reset lands
    assign RamWrite     = (state_q == S_WR) & ~Reset;
    assign Busy         = (state_q != S_IDLE);
    assign Done         = (state_q == S_DONE);
    assign Fault        = fault_q;
    assign RData        = rdata_q;
    assign RamAddress   = ramaddr_q;
    assign RamWriteData = ramwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit with a
//                one-cycle-latency word RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:16383];
    int          wr_pulses = 0;
    logic [13:0] last_waddr;
    logic [31:0] last_wdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) u_dut (
        .Clock        (clk),
        .Reset        (rst),
        .Req          (req),
        .Wr           (wr),
        .Size         (size),
        .Signed       (sgn),
        .Addr         (addr),
        .WData        (wdata),
        .Busy         (busy),
        .Done         (done),
        .Fault        (fault),
        .RData        (rdata),
        .RamAddress   (ram_addr),
        .RamWrite     (ram_we),
        .RamWriteData (ram_wdata),
        .RamReadData  (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_pulses     <= wr_pulses + 1;
            last_waddr    <= ram_addr;
            last_wdata    <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, return cycles from acceptance edge to Done and Fault seen with Done
    task automatic do_op(input logic w, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic flt);
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; sgn = s; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        flt = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk_eq("done_timeout", 32'd0, 32'd1);
        flt = fault;
    endtask

    initial begin
        int          lat;
        logic        flt;
        int          p0;
        int          dones;
        int          idle_between;

        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sgn = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_busy",  {31'd0, busy},  32'd0);
        chk_eq("rst_done",  {31'd0, done},  32'd0);
        chk_eq("rst_fault", {31'd0, fault}, 32'd0);
        chk_eq("rst_we",    {31'd0, ram_we}, 32'd0);
        chk_eq("rst_rdata", rdata, 32'd0);
        chk_eq("rst_raddr", {18'd0, ram_addr}, 32'd0);
        chk_eq("rst_rwdata", ram_wdata, 32'd0);
        rst = 1'b0;

        // Word store / load
        p0 = wr_pulses;
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, flt);
        chk_eq("sw_lat", lat, 2);
        chk_eq("sw_fault", {31'd0, flt}, 32'd0);
        @(negedge clk);
        chk_eq("sw_pulses", wr_pulses - p0, 1);
        chk_eq("sw_waddr", {18'd0, last_waddr}, 32'd4);
        chk_eq("sw_mem", mem[4], 32'hDEADBEEF);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, lat, flt);
        chk_eq("lw_lat", lat, 3);
        chk_eq("lw_rdata", rdata, 32'hDEADBEEF);

        // Byte store read-modify-write
        mem[4] = 32'h11223344;
        p0 = wr_pulses;
        do_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, lat, flt);
        chk_eq("sb_lat", lat, 4);
        @(negedge clk);
        chk_eq("sb_pulses", wr_pulses - p0, 1);
        chk_eq("sb_wdata", last_wdata, 32'h11AB3344);
        chk_eq("sb_mem", mem[4], 32'h11AB3344);

        // Extension checks on word 5
        mem[5] = 32'h80FF7F01;
        do_op(1'b0, 2'b00, 1'b1, 32'h14, 32'd0, lat, flt);
        chk_eq("lb_s", rdata, 32'hFFFFFF80);
        do_op(1'b0, 2'b00, 1'b0, 32'h14, 32'd0, lat, flt);
        chk_eq("lbu", rdata, 32'h00000080);
        do_op(1'b0, 2'b00, 1'b1, 32'h17, 32'd0, lat, flt);
        chk_eq("lb_s_off3", rdata, 32'h00000001);
        do_op(1'b0, 2'b00, 1'b1, 32'h15, 32'd0, lat, flt);
        chk_eq("lb_s_off1", rdata, 32'hFFFFFFFF);
        do_op(1'b0, 2'b01, 1'b1, 32'h14, 32'd0, lat, flt);
        chk_eq("lh_s_off0", rdata, 32'hFFFF80FF);
        do_op(1'b0, 2'b01, 1'b0, 32'h14, 32'd0, lat, flt);
        chk_eq("lhu_off0", rdata, 32'h000080FF);
        do_op(1'b0, 2'b01, 1'b1, 32'h16, 32'd0, lat, flt);
        chk_eq("lh_s_off2", rdata, 32'h00007F01);

        // Faults: latency 1, no write, RData untouched
        p0 = wr_pulses;
        do_op(1'b0, 2'b10, 1'b0, 32'h12, 32'd0, lat, flt);
        chk_eq("f_word_lat", lat, 1);
        chk_eq("f_word_flt", {31'd0, flt}, 32'd1);
        do_op(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, lat, flt);
        chk_eq("f_half_lat", lat, 1);
        chk_eq("f_half_flt", {31'd0, flt}, 32'd1);
        do_op(1'b1, 2'b10, 1'b0, 32'h00010000, 32'h1, lat, flt);
        chk_eq("f_range_lat", lat, 1);
        chk_eq("f_range_flt", {31'd0, flt}, 32'd1);
        do_op(1'b0, 2'b11, 1'b0, 32'h20, 32'd0, lat, flt);
        chk_eq("f_size_lat", lat, 1);
        chk_eq("f_size_flt", {31'd0, flt}, 32'd1);
        @(negedge clk);
        chk_eq("f_clear", {31'd0, fault}, 32'd0);
        chk_eq("f_pulses", wr_pulses - p0, 0);
        chk_eq("f_rdata", rdata, 32'h00007F01);

        // Reset landing in the WR cycle of a half store to word 6
        mem[6] = 32'h12345678;
        p0 = wr_pulses;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b01; sgn = 1'b0; addr = 32'h18; wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rw_we_pre", {31'd0, ram_we}, 32'd1);
        chk_eq("rw_merge", ram_wdata, 32'hBEEF5678);
        rst = 1'b1;
        #1;
        chk_eq("rw_we_rst", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_eq("rw_busy", {31'd0, busy}, 32'd0);
        chk_eq("rw_done", {31'd0, done}, 32'd0);
        chk_eq("rw_mem", mem[6], 32'h12345678);
        chk_eq("rw_pulses", wr_pulses - p0, 0);

        // Req held high across two word stores
        p0 = wr_pulses;
        dones = 0;
        idle_between = 0;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hA5A5A5A5;
        for (int c = 0; c < 20 && dones < 2; c++) begin
            @(negedge clk);
            if (!busy && dones == 1) idle_between++;
            if (done) dones++;
        end
        req = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rq_dones", dones, 2);
        chk_eq("rq_pulses", wr_pulses - p0, 2);
        chk_eq("rq_idle_gap", {31'd0, idle_between >= 1}, 32'd1);
        chk_eq("rq_mem", mem[8], 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
